ice_responder: RTL and testbench

//  Target end of the ICE command bus, inside core on CLK_CPU; ice is the initiator. Decodes ICE_BUS_CMD/FROMICE,

---
 rtl/ice_responder_pkg.sv | 37 +++
 rtl/ice_responder.sv | 174 +++++++++++++++++
 tb/tb_ice_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ice_responder_pkg.sv
// Shared ICE bus definitions: command codes, response codes and responder FSM states.
// The ice initiator uses the same codes.
package ice_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RD_WAIT,
      ST_FILL,
      ST_RESPOND
   } state_t;

   localparam logic [7:0] CMD_IDLE     = 8'h00;
   localparam logic [7:0] CMD_PING     = 8'h01;
   localparam logic [7:0] CMD_SET_ADDR = 8'h02;
   localparam logic [7:0] CMD_VRAM_RD  = 8'h03;
   localparam logic [7:0] CMD_VRAM_WR  = 8'h04;
   localparam logic [7:0] CMD_HALT     = 8'h05;
   localparam logic [7:0] CMD_RUN      = 8'h06;
   localparam logic [7:0] CMD_READ_SW  = 8'h07;
   localparam logic [7:0] CMD_SET_LEN  = 8'h08;
   localparam logic [7:0] CMD_FILL     = 8'h09;

   localparam logic [7:0] RESP_NONE        = 8'h00;
   localparam logic [7:0] RESP_OK_BIT      = 8'h80;
   localparam logic [7:0] RESP_ERR_BADCMD  = 8'hEE;
   localparam logic [7:0] RESP_ERR_NOTHALT = 8'hEB;

   function automatic logic is_known_cmd(input logic [7:0] cmd);
      return (cmd >= CMD_PING) && (cmd <= CMD_FILL);
   endfunction

   function automatic logic is_vram_cmd(input logic [7:0] cmd);
      return (cmd == CMD_VRAM_RD) || (cmd == CMD_VRAM_WR) || (cmd == CMD_FILL);
   endfunction

endpackage

// File: rtl/ice_responder.sv
// Target end of the ICE command bus: 4-phase handshake, CPU halt/run, VRAM peek/poke/fill.
// state      | meaning
// ST_IDLE    | waiting for CMD != 0, latches CMD and operand
// ST_EXEC    | decode and execute single-cycle commands, launch read/fill
// ST_RD_WAIT | VRAM read latency down-counter
// ST_FILL    | one WE pulse per cycle, down-counter on remaining words
// ST_RESPOND | RESP/TOICE held until CMD returns to 0
module ice_responder
   import ice_responder_pkg::*;
#(
   parameter int          ADDR_W       = 16,
   parameter int          DATA_W       = 3,
   parameter int          RD_LAT       = 1,
   parameter logic [15:0] VERSION      = 16'hC0DE,
   parameter bit          RESET_HALTED = 1'b0
) (
   input  logic              CLK,
   input  logic              I_NRESET,
   input  logic [7:0]        I_ICE_BUS_CMD,
   output logic [7:0]        O_ICE_BUS_RESP,
   input  logic [15:0]       I_ICE_BUS_FROMICE,
   output logic [15:0]       O_ICE_BUS_TOICE,
   output logic [ADDR_W-1:0] O_VBUS_ADDR,
   output logic              O_VBUS_WE,
   output logic [DATA_W-1:0] O_VBUS_DATA_TOVRAM,
   input  logic [DATA_W-1:0] I_VBUS_DATA_FROMVRAM,
   input  logic [3:0]        I_SW,
   output logic              O_CPU_HALT
);

   state_t            state, state_nxt;
   logic [7:0]        cmd_q, cmd_nxt;
   logic [15:0]       op_q, op_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [15:0]       len, len_nxt;
   logic [15:0]       cnt, cnt_nxt;
   logic [7:0]        resp, resp_nxt;
   logic [15:0]       toice, toice_nxt;
   logic              halt, halt_nxt;
   logic              we;
   logic [7:0]        resp_ok;

   always_ff @(posedge CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state <= ST_IDLE;
         cmd_q <= CMD_IDLE;
         op_q  <= '0;
         ptr   <= '0;
         len   <= '0;
         cnt   <= '0;
         resp  <= RESP_NONE;
         toice <= '0;
         halt  <= RESET_HALTED;
      end else begin
         state <= state_nxt;
         cmd_q <= cmd_nxt;
         op_q  <= op_nxt;
         ptr   <= ptr_nxt;
         len   <= len_nxt;
         cnt   <= cnt_nxt;
         resp  <= resp_nxt;
         toice <= toice_nxt;
         halt  <= halt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd_q;
      op_nxt    = op_q;
      ptr_nxt   = ptr;
      len_nxt   = len;
      cnt_nxt   = cnt;
      resp_nxt  = resp;
      toice_nxt = toice;
      halt_nxt  = halt;
      we        = 1'b0;
      resp_ok   = {1'b0, cmd_q[6:0]} | RESP_OK_BIT;

      case (state)
         ST_IDLE: begin
            if (I_ICE_BUS_CMD != CMD_IDLE) begin
               cmd_nxt   = I_ICE_BUS_CMD;
               op_nxt    = I_ICE_BUS_FROMICE;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_RESPOND;
            resp_nxt  = resp_ok;
            if (!is_known_cmd(cmd_q)) begin
               resp_nxt = RESP_ERR_BADCMD;
            end else if (is_vram_cmd(cmd_q) && !halt) begin
               resp_nxt = RESP_ERR_NOTHALT;
            end else begin
               case (cmd_q)
                  CMD_PING:     toice_nxt = VERSION;
                  CMD_SET_ADDR: begin
                     ptr_nxt   = ADDR_W'(op_q);
                     toice_nxt = op_q;
                  end
                  CMD_VRAM_RD: begin
                     // address is already on the bus; wait out the read latency
                     resp_nxt  = RESP_NONE;
                     cnt_nxt   = 16'(RD_LAT - 1);
                     state_nxt = ST_RD_WAIT;
                  end
                  CMD_VRAM_WR: begin
                     we        = 1'b1;
                     ptr_nxt   = ptr + ADDR_W'(1);
                     toice_nxt = 16'(ptr);
                  end
                  CMD_HALT: begin
                     halt_nxt  = 1'b1;
                     toice_nxt = 16'd1;
                  end
                  CMD_RUN: begin
                     halt_nxt  = 1'b0;
                     toice_nxt = 16'd0;
                  end
                  CMD_READ_SW:  toice_nxt = {12'b0, I_SW};
                  CMD_SET_LEN: begin
                     len_nxt   = op_q;
                     toice_nxt = op_q;
                  end
                  CMD_FILL: begin
                     toice_nxt = len;
                     if (len != 16'd0) begin
                        resp_nxt  = RESP_NONE;
                        cnt_nxt   = len;
                        state_nxt = ST_FILL;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_RD_WAIT: begin
            if (cnt == 16'd0) begin
               toice_nxt = 16'(I_VBUS_DATA_FROMVRAM);
               ptr_nxt   = ptr + ADDR_W'(1);
               resp_nxt  = resp_ok;
               state_nxt = ST_RESPOND;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         ST_FILL: begin
            we      = 1'b1;
            ptr_nxt = ptr + ADDR_W'(1);
            cnt_nxt = cnt - 16'd1;
            if (cnt == 16'd1) begin
               resp_nxt  = resp_ok;
               state_nxt = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            if (I_ICE_BUS_CMD == CMD_IDLE) begin
               resp_nxt  = RESP_NONE;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign O_ICE_BUS_RESP     = resp;
   assign O_ICE_BUS_TOICE    = toice;
   assign O_VBUS_ADDR        = ptr;
   assign O_VBUS_WE          = we;
   assign O_VBUS_DATA_TOVRAM = op_q[DATA_W-1:0];
   assign O_CPU_HALT         = halt;

endmodule

// File: tb/tb_ice_responder.sv
// Directed bench for ice_responder: handshake, halt guard, peek/poke, fill wrap, edge cases, reset abort.
module tb_ice_responder;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 3;
   localparam int RD_LAT = 1;

   logic              CLK = 1'b0;
   logic              I_NRESET = 1'b0;
   logic [7:0]        I_ICE_BUS_CMD = 8'h00;
   logic [7:0]        O_ICE_BUS_RESP;
   logic [15:0]       I_ICE_BUS_FROMICE = 16'h0000;
   logic [15:0]       O_ICE_BUS_TOICE;
   logic [ADDR_W-1:0] O_VBUS_ADDR;
   logic              O_VBUS_WE;
   logic [DATA_W-1:0] O_VBUS_DATA_TOVRAM;
   logic [DATA_W-1:0] I_VBUS_DATA_FROMVRAM;
   logic [3:0]        I_SW = 4'h0;
   logic              O_CPU_HALT;

   int n_cmp = 0;
   int n_err = 0;

   ice_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
      .VERSION(16'hC0DE), .RESET_HALTED(1'b0)
   ) dut (
      .CLK(CLK),
      .I_NRESET(I_NRESET),
      .I_ICE_BUS_CMD(I_ICE_BUS_CMD),
      .O_ICE_BUS_RESP(O_ICE_BUS_RESP),
      .I_ICE_BUS_FROMICE(I_ICE_BUS_FROMICE),
      .O_ICE_BUS_TOICE(O_ICE_BUS_TOICE),
      .O_VBUS_ADDR(O_VBUS_ADDR),
      .O_VBUS_WE(O_VBUS_WE),
      .O_VBUS_DATA_TOVRAM(O_VBUS_DATA_TOVRAM),
      .I_VBUS_DATA_FROMVRAM(I_VBUS_DATA_FROMVRAM),
      .I_SW(I_SW),
      .O_CPU_HALT(O_CPU_HALT)
   );

   always #5 CLK = ~CLK;

   // VRAM model with one-cycle synchronous read, plus a log of every write pulse
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_q;
   int                cyc = 0;
   logic [15:0]       we_addr[$];
   int                we_cyc[$];
   logic [DATA_W-1:0] we_data[$];

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      rd_q <= mem[O_VBUS_ADDR];
      if (O_VBUS_WE === 1'b1) begin
         mem[O_VBUS_ADDR] <= O_VBUS_DATA_TOVRAM;
         we_addr.push_back(O_VBUS_ADDR);
         we_cyc.push_back(cyc);
         we_data.push_back(O_VBUS_DATA_TOVRAM);
      end
   end
   assign I_VBUS_DATA_FROMVRAM = rd_q;

   task automatic clear_log();
      we_addr.delete();
      we_cyc.delete();
      we_data.delete();
   endtask

   task automatic do_cmd(input logic [7:0] c, input logic [15:0] o,
                         output logic [7:0] r, output logic [15:0] t, output int lat);
      @(posedge CLK); #1;
      I_ICE_BUS_CMD = c;
      I_ICE_BUS_FROMICE = o;
      @(posedge CLK); #1;
      lat = 0;
      while (O_ICE_BUS_RESP === 8'h00 && lat < 300) begin
         @(posedge CLK); #1;
         lat++;
      end
      r = O_ICE_BUS_RESP;
      t = O_ICE_BUS_TOICE;
      n_cmp++;
      if (lat >= 300) begin
         n_err++;
         $display("FAIL timeout cmd=%h: no response within %0d cycles", c, lat);
      end
      I_ICE_BUS_CMD = 8'h00;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      I_NRESET = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_cmp += 6;
      if (O_ICE_BUS_RESP !== 8'h00) begin n_err++; $display("FAIL reset_resp got %h want 00", O_ICE_BUS_RESP); end
      if (O_ICE_BUS_TOICE !== 16'h0000) begin n_err++; $display("FAIL reset_toice got %h want 0000", O_ICE_BUS_TOICE); end
      if (O_VBUS_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset_addr got %h want 0000", O_VBUS_ADDR); end
      if (O_VBUS_WE !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", O_VBUS_WE); end
      if (O_VBUS_DATA_TOVRAM !== 3'd0) begin n_err++; $display("FAIL reset_data got %h want 0", O_VBUS_DATA_TOVRAM); end
      if (O_CPU_HALT !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b want 0", O_CPU_HALT); end
      I_NRESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic test_ping();
      int lat;
      @(posedge CLK); #1;
      I_ICE_BUS_CMD = 8'h01;
      @(posedge CLK); #1;
      lat = 0;
      while (O_ICE_BUS_RESP === 8'h00 && lat < 300) begin
         @(posedge CLK); #1;
         lat++;
      end
      n_cmp += 3;
      if (lat !== 1) begin n_err++; $display("FAIL ping_latency got %0d want 1", lat); end
      if (O_ICE_BUS_RESP !== 8'h81) begin n_err++; $display("FAIL ping_resp got %h want 81", O_ICE_BUS_RESP); end
      if (O_ICE_BUS_TOICE !== 16'hC0DE) begin n_err++; $display("FAIL ping_toice got %h want C0DE", O_ICE_BUS_TOICE); end
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++;
      if (O_ICE_BUS_RESP !== 8'h81) begin n_err++; $display("FAIL ping_hold got %h want 81", O_ICE_BUS_RESP); end
      I_ICE_BUS_CMD = 8'h00;
      @(posedge CLK); #1;
      n_cmp += 2;
      if (O_ICE_BUS_RESP !== 8'h00) begin n_err++; $display("FAIL ping_release got %h want 00", O_ICE_BUS_RESP); end
      if (O_ICE_BUS_TOICE !== 16'hC0DE) begin n_err++; $display("FAIL ping_toice_hold got %h want C0DE", O_ICE_BUS_TOICE); end
   endtask

   task automatic test_guard();
      logic [7:0] r; logic [15:0] t; int lat;
      clear_log();
      do_cmd(8'h04, 16'h0005, r, t, lat);
      n_cmp += 3;
      if (r !== 8'hEB) begin n_err++; $display("FAIL guard_wr_resp got %h want EB", r); end
      if (we_addr.size() != 0) begin n_err++; $display("FAIL guard_wr_pulses got %0d want 0", we_addr.size()); end
      if (O_VBUS_ADDR !== 16'h0000) begin n_err++; $display("FAIL guard_ptr got %h want 0000", O_VBUS_ADDR); end
      do_cmd(8'h03, 16'h0000, r, t, lat);
      n_cmp++;
      if (r !== 8'hEB) begin n_err++; $display("FAIL guard_rd_resp got %h want EB", r); end
      do_cmd(8'h05, 16'h0000, r, t, lat);
      n_cmp += 3;
      if (r !== 8'h85) begin n_err++; $display("FAIL halt_resp got %h want 85", r); end
      if (lat !== 1) begin n_err++; $display("FAIL halt_latency got %0d want 1", lat); end
      if (O_CPU_HALT !== 1'b1) begin n_err++; $display("FAIL halt_level got %b want 1", O_CPU_HALT); end
   endtask

   task automatic test_poke_peek();
      logic [7:0] r; logic [15:0] t; int lat;
      do_cmd(8'h02, 16'h0010, r, t, lat);
      n_cmp += 3;
      if (r !== 8'h82) begin n_err++; $display("FAIL setaddr_resp got %h want 82", r); end
      if (t !== 16'h0010) begin n_err++; $display("FAIL setaddr_toice got %h want 0010", t); end
      if (O_VBUS_ADDR !== 16'h0010) begin n_err++; $display("FAIL setaddr_ptr got %h want 0010", O_VBUS_ADDR); end
      clear_log();
      do_cmd(8'h04, 16'h0005, r, t, lat);
      n_cmp += 5;
      if (r !== 8'h84) begin n_err++; $display("FAIL wr_resp got %h want 84", r); end
      if (t !== 16'h0010) begin n_err++; $display("FAIL wr_toice got %h want 0010", t); end
      if (lat !== 1) begin n_err++; $display("FAIL wr_latency got %0d want 1", lat); end
      if (we_addr.size() != 1) begin n_err++; $display("FAIL wr_pulses got %0d want 1", we_addr.size()); end
      else if (we_addr[0] !== 16'h0010 || we_data[0] !== 3'd5) begin
         n_err++; $display("FAIL wr_target got %h/%h want 0010/5", we_addr[0], we_data[0]);
      end
      do_cmd(8'h02, 16'h0010, r, t, lat);
      do_cmd(8'h03, 16'h0000, r, t, lat);
      n_cmp += 4;
      if (r !== 8'h83) begin n_err++; $display("FAIL rd_resp got %h want 83", r); end
      if (t !== 16'h0005) begin n_err++; $display("FAIL rd_toice got %h want 0005", t); end
      if (lat !== RD_LAT + 1) begin n_err++; $display("FAIL rd_latency got %0d want %0d", lat, RD_LAT + 1); end
      if (O_VBUS_ADDR !== 16'h0011) begin n_err++; $display("FAIL rd_ptr got %h want 0011", O_VBUS_ADDR); end
   endtask

   task automatic test_fill_wrap();
      logic [7:0] r; logic [15:0] t; int lat;
      logic [15:0] exp_addr [4];
      exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
      do_cmd(8'h02, 16'hFFFE, r, t, lat);
      do_cmd(8'h08, 16'h0004, r, t, lat);
      n_cmp++;
      if (r !== 8'h88) begin n_err++; $display("FAIL setlen_resp got %h want 88", r); end
      clear_log();
      do_cmd(8'h09, 16'h0003, r, t, lat);
      n_cmp += 5;
      if (r !== 8'h89) begin n_err++; $display("FAIL fill_resp got %h want 89", r); end
      if (t !== 16'h0004) begin n_err++; $display("FAIL fill_toice got %h want 0004", t); end
      if (lat !== 5) begin n_err++; $display("FAIL fill_latency got %0d want 5", lat); end
      if (O_VBUS_ADDR !== 16'h0002) begin n_err++; $display("FAIL fill_ptr got %h want 0002", O_VBUS_ADDR); end
      if (we_addr.size() != 4) begin n_err++; $display("FAIL fill_pulses got %0d want 4", we_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (we_addr[i] !== exp_addr[i] || we_data[i] !== 3'd3 || we_cyc[i] != we_cyc[0] + i) begin
               n_err++;
               $display("FAIL fill_pulse%0d got addr %h data %h cyc+%0d want addr %h data 3 cyc+%0d",
                        i, we_addr[i], we_data[i], we_cyc[i] - we_cyc[0], exp_addr[i], i);
            end
         end
      end
   endtask

   task automatic test_edges();
      logic [7:0] r; logic [15:0] t; int lat;
      do_cmd(8'h08, 16'h0000, r, t, lat);
      clear_log();
      do_cmd(8'h09, 16'h0007, r, t, lat);
      n_cmp += 4;
      if (r !== 8'h89) begin n_err++; $display("FAIL fill0_resp got %h want 89", r); end
      if (lat !== 1) begin n_err++; $display("FAIL fill0_latency got %0d want 1", lat); end
      if (we_addr.size() != 0) begin n_err++; $display("FAIL fill0_pulses got %0d want 0", we_addr.size()); end
      if (O_VBUS_ADDR !== 16'h0002) begin n_err++; $display("FAIL fill0_ptr got %h want 0002", O_VBUS_ADDR); end
      do_cmd(8'h90, 16'h0000, r, t, lat);
      n_cmp++;
      if (r !== 8'hEE) begin n_err++; $display("FAIL badcmd90_resp got %h want EE", r); end
      do_cmd(8'h0A, 16'h0000, r, t, lat);
      n_cmp++;
      if (r !== 8'hEE) begin n_err++; $display("FAIL badcmd0A_resp got %h want EE", r); end
      I_SW = 4'hA;
      do_cmd(8'h07, 16'h0000, r, t, lat);
      n_cmp += 2;
      if (r !== 8'h87) begin n_err++; $display("FAIL readsw_resp got %h want 87", r); end
      if (t !== 16'h000A) begin n_err++; $display("FAIL readsw_toice got %h want 000A", t); end
      do_cmd(8'h02, 16'hFFFF, r, t, lat);
      do_cmd(8'h03, 16'h0000, r, t, lat);
      n_cmp++;
      if (t !== 16'h0003) begin n_err++; $display("FAIL peek_filled got %h want 0003", t); end
      do_cmd(8'h06, 16'h0000, r, t, lat);
      n_cmp += 2;
      if (r !== 8'h86) begin n_err++; $display("FAIL run_resp got %h want 86", r); end
      if (O_CPU_HALT !== 1'b0) begin n_err++; $display("FAIL run_level got %b want 0", O_CPU_HALT); end
      clear_log();
      do_cmd(8'h09, 16'h0001, r, t, lat);
      n_cmp += 2;
      if (r !== 8'hEB) begin n_err++; $display("FAIL run_fill_resp got %h want EB", r); end
      if (we_addr.size() != 0) begin n_err++; $display("FAIL run_fill_pulses got %0d want 0", we_addr.size()); end
   endtask

   task automatic test_reset_mid_fill();
      logic [7:0] r; logic [15:0] t; int lat; int n; int frozen;
      do_cmd(8'h05, 16'h0000, r, t, lat);
      do_cmd(8'h02, 16'h0100, r, t, lat);
      do_cmd(8'h08, 16'd100, r, t, lat);
      clear_log();
      @(posedge CLK); #1;
      I_ICE_BUS_CMD = 8'h09;
      I_ICE_BUS_FROMICE = 16'h0002;
      n = 0;
      while (we_addr.size() < 10 && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      n_cmp++;
      if (we_addr.size() < 10) begin n_err++; $display("FAIL midfill_start got %0d pulses want 10", we_addr.size()); end
      I_NRESET = 1'b0;
      #1;
      n_cmp += 4;
      if (O_VBUS_WE !== 1'b0) begin n_err++; $display("FAIL midfill_we got %b want 0", O_VBUS_WE); end
      if (O_ICE_BUS_RESP !== 8'h00) begin n_err++; $display("FAIL midfill_resp got %h want 00", O_ICE_BUS_RESP); end
      if (O_VBUS_ADDR !== 16'h0000) begin n_err++; $display("FAIL midfill_ptr got %h want 0000", O_VBUS_ADDR); end
      if (O_CPU_HALT !== 1'b0) begin n_err++; $display("FAIL midfill_halt got %b want 0", O_CPU_HALT); end
      frozen = we_addr.size();
      I_ICE_BUS_CMD = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      I_NRESET = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      n_cmp += 2;
      if (we_addr.size() != frozen) begin n_err++; $display("FAIL midfill_extra got %0d pulses want %0d", we_addr.size(), frozen); end
      if (O_VBUS_ADDR !== 16'h0000) begin n_err++; $display("FAIL midfill_ptr_after got %h want 0000", O_VBUS_ADDR); end
   endtask

   initial begin
      test_reset();
      test_ping();
      test_guard();
      test_poke_peek();
      test_fill_wrap();
      test_edges();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
